// File: rtl/datapath_pkg.sv
// Shared datapath constants: widths, ALU op encodings, hardwired-zero register index.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package datapath_pkg;

   localparam int DATA_W = 16;
   localparam int REG_AW = 3;

   // 2-bit operation codes understood by the downstream ALU
   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_AND = 2'b01,
      ALU_OR  = 2'b10,
      ALU_SUB = 2'b11
   } alu_op_e;

   // R0 reads as zero and ignores writes
   localparam logic [REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Issue/writeback inputs and registered ALU operand outputs of the operand stage.
// Latency: n/a (wiring only).
// Backpressure: stall travels upstream-to-stage alongside the instruction fields.
interface alu_operand_stage_if #(
   parameter int DATA_W = datapath_pkg::DATA_W,
   parameter int REG_AW = datapath_pkg::REG_AW
);

   // instruction issue side
   logic              issue;
   logic              stall;
   logic [REG_AW-1:0] rs1_addr;
   logic [REG_AW-1:0] rs2_addr;
   logic [REG_AW-1:0] rd_addr;
   logic [DATA_W-1:0] imm;
   logic              use_imm;
   logic [1:0]        aluop_in;

   // writeback side
   logic              wr_en;
   logic [REG_AW-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   // registered outputs towards the ALU
   logic [DATA_W-1:0] aluA_in;
   logic [DATA_W-1:0] aluB_in;
   logic [1:0]        aluop;
   logic [REG_AW-1:0] rd_out;
   logic              valid_out;

   modport master (
      output issue, stall, rs1_addr, rs2_addr, rd_addr, imm, use_imm, aluop_in,
      output wr_en, wr_addr, wr_data,
      input  aluA_in, aluB_in, aluop, rd_out, valid_out
   );

   modport slave (
      input  issue, stall, rs1_addr, rs2_addr, rd_addr, imm, use_imm, aluop_in,
      input  wr_en, wr_addr, wr_data,
      output aluA_in, aluB_in, aluop, rd_out, valid_out
   );

endinterface

// File: rtl/regfile_8x16.sv
// 8-entry register file, R0 hardwired to zero, two read ports with write-through bypass.
// Latency: reads combinational; writes land on the rising edge.
// Backpressure: none; writes are always accepted.
module regfile_8x16 #(
   parameter int DATA_W = datapath_pkg::DATA_W,
   parameter int REG_AW = datapath_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [REG_AW-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [REG_AW-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b
);
   import datapath_pkg::*;

   localparam int NREG = 1 << REG_AW;
   localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(REG_ZERO);

   logic [DATA_W-1:0] mem [NREG];
   logic              wr_live;

   // a write to R0 is never live, so it can neither update storage nor bypass
   assign wr_live = wr_en && (wr_addr != ZERO_IDX);

   // storage: reset clears every entry and wins over a concurrent write
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_live) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // read port A: R0 -> 0, same-cycle writeback -> wr_data, else stored value
   always_comb begin
      rd_data_a = mem[rd_addr_a];
      if (rd_addr_a == ZERO_IDX) begin
         rd_data_a = '0;
      end else if (wr_live && (wr_addr == rd_addr_a)) begin
         rd_data_a = wr_data;
      end
   end

   // read port B: same rules as port A, evaluated independently
   always_comb begin
      rd_data_b = mem[rd_addr_b];
      if (rd_addr_b == ZERO_IDX) begin
         rd_data_b = '0;
      end else if (wr_live && (wr_addr == rd_addr_b)) begin
         rd_data_b = wr_data;
      end
   end

endmodule

// File: rtl/alu_operand_stage.sv
// Register-read / operand-latch stage feeding the ALU, with immediate select and writeback bypass.
// Latency: 1 cycle from issue to registered operands.
// Backpressure: stall freezes all output registers; instructions presented during stall are dropped.
module alu_operand_stage #(
   parameter int DATA_W = datapath_pkg::DATA_W,
   parameter int REG_AW = datapath_pkg::REG_AW
) (
   input  logic               CLK,
   input  logic               Reset,
   alu_operand_stage_if.slave bus
);

   logic [DATA_W-1:0] read_a;
   logic [DATA_W-1:0] read_b;
   logic [DATA_W-1:0] op_b;

   regfile_8x16 #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_regfile (
      .clk       (CLK),
      .rst       (Reset),
      .wr_en     (bus.wr_en),
      .wr_addr   (bus.wr_addr),
      .wr_data   (bus.wr_data),
      .rd_addr_a (bus.rs1_addr),
      .rd_data_a (read_a),
      .rd_addr_b (bus.rs2_addr),
      .rd_data_b (read_b)
   );

   // the immediate fully replaces the rs2 read, bypass included
   assign op_b = bus.use_imm ? bus.imm : read_b;

   // output pipeline register: reset > stall (hold) > issue (load) > bubble (zero)
   always_ff @(posedge CLK) begin
      if (Reset) begin
         bus.aluA_in   <= '0;
         bus.aluB_in   <= '0;
         bus.aluop     <= '0;
         bus.rd_out    <= '0;
         bus.valid_out <= 1'b0;
      end else if (bus.stall) begin
         bus.aluA_in   <= bus.aluA_in;
         bus.aluB_in   <= bus.aluB_in;
         bus.aluop     <= bus.aluop;
         bus.rd_out    <= bus.rd_out;
         bus.valid_out <= bus.valid_out;
      end else if (bus.issue) begin
         bus.aluA_in   <= read_a;
         bus.aluB_in   <= op_b;
         bus.aluop     <= bus.aluop_in;
         bus.rd_out    <= bus.rd_addr;
         bus.valid_out <= 1'b1;
      end else begin
         bus.aluA_in   <= '0;
         bus.aluB_in   <= '0;
         bus.aluop     <= '0;
         bus.rd_out    <= '0;
         bus.valid_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed vectors, stall/reset sequences, random scoreboard.
// Latency: expects registered outputs one edge after inputs are presented.
// Backpressure: exercises stall holding outputs across several edges.
module tb_alu_operand_stage;
   import datapath_pkg::*;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  op;
      logic [2:0]  rd;
      logic        vld;
   } out_t;

   typedef struct {
      logic        issue;
      logic [2:0]  rs1;
      logic [2:0]  rs2;
      logic [2:0]  rd;
      logic        use_imm;
      logic [15:0] imm;
      logic [1:0]  op;
      logic        wr_en;
      logic [2:0]  wa;
      logic [15:0] wd;
      out_t        exp;
   } vec_t;

   logic CLK = 1'b0;
   logic Reset;
   int   checks = 0;
   int   errors = 0;

   alu_operand_stage_if #(.DATA_W(16), .REG_AW(3)) bus ();

   alu_operand_stage #(.DATA_W(16), .REG_AW(3)) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   vec_t        vecs [12];
   logic [15:0] ref_r [8];
   out_t        exp_q [$];

   function automatic vec_t mk(logic issue, logic [2:0] rs1, logic [2:0] rs2, logic [2:0] rd,
                               logic use_imm, logic [15:0] imm, logic [1:0] op,
                               logic wr_en, logic [2:0] wa, logic [15:0] wd,
                               logic [15:0] ea, logic [15:0] eb, logic [1:0] eop,
                               logic [2:0] erd, logic ev);
      vec_t v;
      v.issue = issue; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
      v.use_imm = use_imm; v.imm = imm; v.op = op;
      v.wr_en = wr_en; v.wa = wa; v.wd = wd;
      v.exp.a = ea; v.exp.b = eb; v.exp.op = eop; v.exp.rd = erd; v.exp.vld = ev;
      return v;
   endfunction

   function automatic out_t zero_out();
      out_t o;
      o.a = '0; o.b = '0; o.op = '0; o.rd = '0; o.vld = 1'b0;
      return o;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input out_t e);
      chk($sformatf("%s.aluA_in", tag),   32'(bus.aluA_in),   32'(e.a));
      chk($sformatf("%s.aluB_in", tag),   32'(bus.aluB_in),   32'(e.b));
      chk($sformatf("%s.aluop", tag),     32'(bus.aluop),     32'(e.op));
      chk($sformatf("%s.rd_out", tag),    32'(bus.rd_out),    32'(e.rd));
      chk($sformatf("%s.valid_out", tag), 32'(bus.valid_out), 32'(e.vld));
   endtask

   task automatic drive(input logic issue, input logic stall, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [2:0] rd, input logic use_imm,
                        input logic [15:0] imm, input logic [1:0] op, input logic wr_en,
                        input logic [2:0] wa, input logic [15:0] wd);
      bus.issue = issue; bus.stall = stall;
      bus.rs1_addr = rs1; bus.rs2_addr = rs2; bus.rd_addr = rd;
      bus.use_imm = use_imm; bus.imm = imm; bus.aluop_in = op;
      bus.wr_en = wr_en; bus.wr_addr = wa; bus.wr_data = wd;
   endtask

   function automatic out_t mk_out(logic [15:0] a, logic [15:0] b, logic [1:0] op,
                                   logic [2:0] rd, logic v);
      out_t o;
      o.a = a; o.b = b; o.op = op; o.rd = rd; o.vld = v;
      return o;
   endfunction

   initial begin
      logic [15:0] diff;
      out_t        model_out;
      out_t        nxt;
      out_t        got;
      logic [15:0] rda;
      logic [15:0] rdb;
      logic        r_rst;

      Reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 16'h0, 2'b00, 0, 0, 16'h0);

      // directed table: {inputs, expected outputs one edge later}
      vecs[0]  = mk(0, 0, 0, 0, 0, 16'h0,    ALU_ADD, 1, 3, 16'd32,   16'h0,    16'h0,    2'b00, 3'd0, 0);
      vecs[1]  = mk(0, 0, 0, 0, 0, 16'h0,    ALU_ADD, 1, 4, 16'd32,   16'h0,    16'h0,    2'b00, 3'd0, 0);
      vecs[2]  = mk(1, 3, 4, 6, 0, 16'h0,    ALU_SUB, 0, 0, 16'h0,    16'd32,   16'd32,   2'b11, 3'd6, 1);
      vecs[3]  = mk(1, 5, 0, 2, 0, 16'h0,    ALU_ADD, 1, 5, 16'h1234, 16'h1234, 16'h0,    2'b00, 3'd2, 1);
      vecs[4]  = mk(0, 0, 0, 0, 0, 16'h0,    ALU_ADD, 1, 0, 16'hFFFF, 16'h0,    16'h0,    2'b00, 3'd0, 0);
      vecs[5]  = mk(1, 0, 0, 1, 0, 16'h0,    ALU_OR,  0, 0, 16'h0,    16'h0,    16'h0,    2'b10, 3'd1, 1);
      vecs[6]  = mk(0, 0, 0, 0, 0, 16'h0,    ALU_ADD, 1, 2, 16'd7,    16'h0,    16'h0,    2'b00, 3'd0, 0);
      vecs[7]  = mk(1, 5, 2, 1, 1, 16'h00A5, ALU_AND, 0, 0, 16'h0,    16'h1234, 16'h00A5, 2'b01, 3'd1, 1);
      vecs[8]  = mk(1, 2, 2, 7, 0, 16'h00A5, ALU_OR,  0, 0, 16'h0,    16'd7,    16'd7,    2'b10, 3'd7, 1);
      vecs[9]  = mk(1, 1, 5, 3, 0, 16'h0,    ALU_ADD, 1, 1, 16'd9,    16'd9,    16'h1234, 2'b00, 3'd3, 1);
      vecs[10] = mk(1, 5, 5, 4, 0, 16'h0,    ALU_SUB, 1, 5, 16'hBEEF, 16'hBEEF, 16'hBEEF, 2'b11, 3'd4, 1);
      vecs[11] = mk(1, 6, 6, 5, 1, 16'h0F0F, ALU_AND, 1, 6, 16'h5555, 16'h5555, 16'h0F0F, 2'b01, 3'd5, 1);

      // reset held two edges, then released with a bubble
      tick();
      tick();
      check_out("reset", zero_out());
      Reset = 1'b0;
      tick();
      check_out("post_reset_bubble", zero_out());

      // every general register reads zero after reset
      for (int i = 1; i < 8; i++) begin
         drive(1, 0, 3'(i), 3'(i), 3'(i), 0, 16'h0, 2'b00, 0, 0, 16'h0);
         tick();
         check_out($sformatf("reset_R%0d", i), mk_out(16'h0, 16'h0, 2'b00, 3'(i), 1));
      end

      // table-driven vectors
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].issue, 0, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].use_imm,
               vecs[i].imm, vecs[i].op, vecs[i].wr_en, vecs[i].wa, vecs[i].wd);
         tick();
         check_out($sformatf("vec%0d", i), vecs[i].exp);
         if (i == 2) begin
            diff = bus.aluA_in - bus.aluB_in;
            chk("vec2_sub_is_zero", 32'(diff), 32'h0);
         end
      end

      // stall: load A=R1(9), B=R3(32), then hold for three edges while a new instruction is presented
      drive(1, 0, 1, 3, 2, 0, 16'h0, ALU_SUB, 0, 0, 16'h0);
      tick();
      check_out("stall_load", mk_out(16'd9, 16'd32, 2'b11, 3'd2, 1));
      drive(1, 1, 2, 2, 7, 0, 16'h0, ALU_ADD, 1, 7, 16'h0077);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_out($sformatf("stall_hold%0d", i), mk_out(16'd9, 16'd32, 2'b11, 3'd2, 1));
      end
      drive(0, 0, 2, 2, 7, 0, 16'h0, ALU_ADD, 0, 0, 16'h0);
      tick();
      check_out("stall_release_bubble", zero_out());
      // the write presented during the stall must still have landed
      drive(1, 0, 7, 0, 1, 0, 16'h0, ALU_ADD, 0, 0, 16'h0);
      tick();
      check_out("write_during_stall", mk_out(16'h0077, 16'h0, 2'b00, 3'd1, 1));

      // reset mid-stream overrides both the output register and a concurrent write
      drive(1, 0, 3, 3, 6, 0, 16'h0, ALU_SUB, 0, 0, 16'h0);
      tick();
      check_out("pre_reset_valid", mk_out(16'd32, 16'd32, 2'b11, 3'd6, 1));
      Reset = 1'b1;
      drive(1, 0, 3, 3, 6, 0, 16'h0, ALU_SUB, 1, 3, 16'hAAAA);
      tick();
      check_out("mid_reset", zero_out());
      Reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 16'h0, ALU_ADD, 0, 0, 16'h0);
      tick();
      check_out("mid_reset_release", zero_out());
      drive(1, 0, 3, 1, 5, 0, 16'h0, ALU_OR, 0, 0, 16'h0);
      tick();
      check_out("R3_after_reset", mk_out(16'h0, 16'h0, 2'b10, 3'd5, 1));

      // random traffic against a reference model; expectations queued at drive time
      model_out = zero_out();
      for (int i = 0; i < 8; i++) ref_r[i] = 16'h0;
      for (int n = 0; n < 400; n++) begin
         r_rst = (n == 0) || ($urandom_range(0, 49) == 0);
         Reset = r_rst;
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));

         if (bus.rs1_addr == 3'd0) rda = 16'h0;
         else if (bus.wr_en && bus.wr_addr == bus.rs1_addr) rda = bus.wr_data;
         else rda = ref_r[bus.rs1_addr];
         if (bus.use_imm) rdb = bus.imm;
         else if (bus.rs2_addr == 3'd0) rdb = 16'h0;
         else if (bus.wr_en && bus.wr_addr == bus.rs2_addr) rdb = bus.wr_data;
         else rdb = ref_r[bus.rs2_addr];

         if (r_rst) nxt = zero_out();
         else if (bus.stall) nxt = model_out;
         else if (bus.issue) nxt = mk_out(rda, rdb, bus.aluop_in, bus.rd_addr, 1);
         else nxt = zero_out();
         model_out = nxt;
         exp_q.push_back(nxt);

         if (r_rst) begin
            for (int i = 0; i < 8; i++) ref_r[i] = 16'h0;
         end else if (bus.wr_en && bus.wr_addr != 3'd0) begin
            ref_r[bus.wr_addr] = bus.wr_data;
         end

         tick();
         if (exp_q.size() == 0) begin
            chk("scoreboard_underflow", 32'd1, 32'd0);
         end else begin
            got = exp_q.pop_front();
            check_out($sformatf("rand%0d", n), got);
         end
      end
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Register-read / operand-latch stage directly upstream of the ALU. It holds the 8×16 general-purpose register file, selects each operand from a register or from the immediate, and registers `aluA_in`, `aluB_in` and `aluop` for the ALU on the next clock edge. It also forwards same-cycle writeback data so the ALU never sees stale values. The destination register address is piped alongside the operands so writeback can return results to this block.

## Interface
Parameters:
- DATA_W, 16, datapath width; must equal ALU operand width
- REG_AW, 3, register address width (8 registers)

Ports:
- CLK  in  1  system clock, rising-edge
- Reset  in  1  synchronous, active-high reset
- issue  in  1  instruction valid this cycle
- stall  in  1  hold all output registers (downstream not ready)
- rs1_addr  in  REG_AW  operand A source register
- rs2_addr  in  REG_AW  operand B source register
- rd_addr  in  REG_AW  destination register, piped to rd_out
- imm  in  DATA_W  immediate operand
- use_imm  in  1  1: operand B = imm; 0: operand B = R[rs2_addr]
- aluop_in  in  2  ALU operation, piped unchanged
- wr_en  in  1  writeback enable
- wr_addr  in  REG_AW  writeback register
- wr_data  in  DATA_W  writeback data
- aluA_in  out  DATA_W  registered operand A to ALU
- aluB_in  out  DATA_W  registered operand B to ALU
- aluop  out  2  registered ALU op
- rd_out  out  REG_AW  registered destination address
- valid_out  out  1  outputs hold a real instruction

## Operation
- Register file: 8 entries × DATA_W. R0 always reads 0. Writes to R0 are discarded.
- Write: on a rising edge with wr_en=1 and wr_addr≠0, R[wr_addr] <= wr_data. Writes happen regardless of stall and issue.
- Read is combinational, with write-through bypass. If wr_en=1, wr_addr≠0 and wr_addr equals the read address, the read returns wr_data, not the stored value. This applies independently to rs1 and rs2.
- Operand B mux: use_imm=1 selects imm. The rs2 read and its bypass are ignored in that case.
- Output register update, in priority order each rising edge:
  - Reset=1: all outputs 0, valid_out=0, all registers R1–R7 cleared to 0. Reset overrides a concurrent write.
  - stall=1: all output registers hold their value, including valid_out.
  - issue=1: aluA_in <= readA, aluB_in <= opB, aluop <= aluop_in, rd_out <= rd_addr, valid_out <= 1.
  - issue=0 (bubble): aluA_in, aluB_in, aluop and rd_out <= 0; valid_out <= 0.
- No arithmetic in this block. Values pass at full DATA_W width with no extension or truncation.

## Timing
- Latency: inputs sampled at edge N appear on the outputs after edge N, and the ALU consumes them in cycle N+1.
- Bypass is combinational: a wr_data written at edge N is captured into the operand at that same edge N.
- Stall held for k cycles freezes the outputs for k cycles. The issue and address inputs presented during a stall are dropped; upstream must re-present them.
- Reset mid-operation: the first edge with Reset=1 clears everything. Outputs read 0 and valid_out=0 from that edge until the first non-reset edge with issue=1.
- After reset, the first operand registration can occur on the first edge where Reset=0.

## Structure
- Shared package (`datapath_pkg`) holds:
  - DATA_W and REG_AW
  - the 2-bit ALU op encodings used by the ALU, including ALU_SUB = 2'b11
  - REG_ZERO = 0
- One sub-module, `regfile_8x16`: storage, synchronous reset, R0 hardwiring, two combinational read ports with bypass, one write port.
- The top level contains the operand-B mux and the output pipeline register with stall/bubble control.

## Test plan
- Reset: Reset=1 for 2 cycles, then release with issue=0 → all outputs 0, valid_out=0. Reading R1–R7 then gives 0.
- Write then read: write R3=32 and R4=32; then issue rs1=3, rs2=4, use_imm=0, aluop_in=2'b11 → next cycle aluA_in=32, aluB_in=32, aluop=11, valid_out=1. The ALU produces alu_out=0 and isZero=1.
- Bypass and R0: in the same cycle wr_en=1, wr_addr=5, wr_data=0x1234 and issue rs1=5 → aluA_in=0x1234. A write of 0xFFFF to R0, then issue rs1=0 → aluA_in=0.
- Immediate: R2=7, issue rs2=2, use_imm=1, imm=0x00A5 → aluB_in=0x00A5.
- Stall and bubble: issue A=R1(=9), then stall=1 for 3 cycles while a different instruction is presented → outputs stay 9/valid for 3 cycles. Release with issue=0 → outputs 0, valid_out=0.
- Reset mid-stream: outputs valid with aluA_in=32, and R3 is written in the same edge that Reset=1 → outputs 0, valid_out=0, R3 reads 0 afterwards.
